count_arbiter: RTL and testbench
================================

COUNT_ARBITER -- requirements
Module: count_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, counter data width in bits.
REQ-002 Parameter LEN_W, default 4, run-length field width in bits.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port req  input  2  per-requester request, level; bit i = requester i.
REQ-006 Port data0 / data1  input  WIDTH  preload value of requester 0 / 1.
REQ-007 Port len0 / len1  input  LEN_W  count-cycle run length of requester 0 / 1.
REQ-008 Port gnt  output  2  one-hot grant, high LOAD through DONE.
REQ-009 Port done  output  2  one-cycle completion pulse to granted requester.
REQ-010 Port busy  output  1  high whenever state is not IDLE.
REQ-011 Port ctr_load  output  1  counter load strobe.
REQ-012 Port ctr_load_data  output  WIDTH  counter load value.
REQ-013 Port ctr_count_en  output  1  counter increment enable.
REQ-014 Port ctr_output_en  output  1  counter output-drive enable.

Function
REQ-015 The block SHALL implement a four-state FSM: IDLE, LOAD, RUN, DONE.
REQ-016 All outputs SHALL decode from registered state/latches only; no combinational input-to-output path.
REQ-017 IDLE: with req != 0, the winner's index, data and len SHALL be latched and state SHALL go to LOAD next cycle.
REQ-018 IDLE with req == 0 SHALL remain IDLE, all outputs 0.
REQ-019 LOAD: ctr_load=1 for exactly one cycle, ctr_load_data = latched data; next state RUN if latched len != 0, else DONE.
REQ-020 RUN: ctr_count_en=1 for exactly len consecutive cycles (remaining-count register decrements each cycle; exit to DONE when remaining == 1).
REQ-021 DONE: ctr_output_en=1 and done[winner]=1 for exactly one cycle; next state IDLE.
REQ-022 gnt[winner]=1 in LOAD, RUN, DONE; gnt=0 in IDLE.
REQ-023 Transaction latency SHALL be len+3 cycles from request-sampling edge to return to IDLE; no back-to-back grant without one IDLE cycle.
REQ-024 req SHALL be sampled only in IDLE; changes to req, dataX, lenX during a transaction SHALL be ignored and the transaction SHALL complete.
REQ-025 Default arbitration SHALL be round-robin: when both request, grant the requester not served last; a single requester always wins.
REQ-026 The last-served pointer SHALL update on entry to LOAD.
REQ-027 ctr_load, ctr_count_en, ctr_output_en SHALL be mutually exclusive in every cycle.
REQ-028 len = 2^LEN_W-1 SHALL yield that many count cycles; no wrap of remaining counter.

Reset
REQ-029 rst high SHALL immediately force state IDLE, gnt=0, done=0, busy=0, ctr_load=0, ctr_load_data=0, ctr_count_en=0, ctr_output_en=0.
REQ-030 Reset SHALL set the last-served pointer to 1 so requester 0 wins the first tie.
REQ-031 Reset mid-transaction SHALL abort with no done pulse; first post-reset transaction SHALL follow REQ-030.

Configuration
REQ-032 Macro COUNT_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win ties (pointer unused); when undefined, round-robin per REQ-025.

Verification
REQ-033 Reset, then req=01, data0=0x10, len0=3 -> LOAD 1 cycle with load_data 0x10, count_en 3 cycles, done=01 one cycle, gnt=01 for 5 cycles.
REQ-034 req=11 held continuously, len0=len1=1 -> grants alternate 01,10,01,10 (fixed 01 each time with COUNT_ARB_FIXED_PRIO_EN).
REQ-035 req=10, len1=0, data1=0xFF -> LOAD then DONE directly, zero count_en cycles, done=10.
REQ-036 rst pulsed during RUN (len0=8, 4th count cycle) -> all outputs 0 same cycle, no done pulse, next req=11 grants 01.
REQ-037 Change data0/len0 and drop req mid-RUN -> count_en length and load_data unchanged from latched values.
REQ-038 len0=15 (LEN_W=4) -> exactly 15 count_en cycles; load/count_en/output_en never overlap across all tests.

Source files
------------

// File: rtl/count_arbiter.sv
// Two-requester arbiter sequencing a shared counter through LOAD/RUN/DONE.
// Define COUNT_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module count_arbiter #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic             ctr_load,
  output logic [WIDTH-1:0] ctr_load_data,
  output logic             ctr_count_en,
  output logic             ctr_output_en
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic             win;
  logic [WIDTH-1:0] data_q;
  logic [LEN_W-1:0] rem;
  logic             pick;

`ifdef COUNT_ARB_FIXED_PRIO_EN
  always_comb begin
    pick = ~req[0];
  end
`else
  logic last;

  // On a tie, serve whoever was not served last.
  always_comb begin
    pick = req[1];
    if (req[0] && req[1])
      pick = ~last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= 1'b1;
    else if (state == IDLE && req != 2'b00)
      last <= pick;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      win    <= 1'b0;
      data_q <= '0;
      rem    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            win    <= pick;
            data_q <= pick ? data1 : data0;
            rem    <= pick ? len1 : len0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          state <= (rem != '0) ? RUN : DONE;
        end
        RUN: begin
          rem <= rem - 1'b1;
          if (rem == LEN_W'(1))
            state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  logic [1:0] win_hot;
  assign win_hot = win ? 2'b10 : 2'b01;

  assign busy          = (state != IDLE);
  assign gnt           = busy ? win_hot : 2'b00;
  assign done          = (state == DONE) ? win_hot : 2'b00;
  assign ctr_load      = (state == LOAD);
  assign ctr_load_data = (state == LOAD) ? data_q : '0;
  assign ctr_count_en  = (state == RUN);
  assign ctr_output_en = (state == DONE);

endmodule

// File: tb/tb_count_arbiter.sv
// Bench for count_arbiter: directed scenarios plus random transactions
// checked cycle by cycle against a transaction-level reference model.
module tb_count_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [7:0] data0, data1;
  logic [3:0] len0, len1;
  logic [1:0] gnt, done;
  logic       busy, ctr_load, ctr_count_en, ctr_output_en;
  logic [7:0] ctr_load_data;

  int cmp_n = 0;
  int err_n = 0;
  bit last_m = 1'b1;

  always #5 clk = ~clk;

  count_arbiter #(.WIDTH(8), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1),
    .len0(len0), .len1(len1),
    .gnt(gnt), .done(done), .busy(busy),
    .ctr_load(ctr_load), .ctr_load_data(ctr_load_data),
    .ctr_count_en(ctr_count_en), .ctr_output_en(ctr_output_en)
  );

  function automatic logic [15:0] obs();
    return {gnt, done, busy, ctr_load, ctr_load_data,
            ctr_count_en, ctr_output_en};
  endfunction

  task automatic chk(input string tag, input logic [15:0] o,
                     input logic [15:0] e);
    cmp_n++;
    assert (o === e) else begin
      err_n++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
    cmp_n++;
    assert ($countones({ctr_load, ctr_count_en, ctr_output_en}) <= 1)
    else begin
      err_n++;
      $error("FAIL %s_excl observed=%b expected=onehot0", tag,
             {ctr_load, ctr_count_en, ctr_output_en});
    end
  endtask

  // One transaction from an IDLE negedge; mut/abort name a cycle number.
  task automatic txn(input string tag, input logic [1:0] r,
                     input logic [7:0] d0, input logic [7:0] d1,
                     input logic [3:0] l0, input logic [3:0] l1,
                     input int mut, input int abort);
    bit w;
    logic [7:0] d;
    int l;
    logic [1:0] g;
    logic [15:0] e;
    req = r; data0 = d0; data1 = d1; len0 = l0; len1 = l1;
    if (r == 2'b00) begin
      @(negedge clk);
      chk({tag, "_idle"}, obs(), 16'h0);
      return;
    end
`ifdef COUNT_ARB_FIXED_PRIO_EN
    w = (r == 2'b10);
`else
    w = (r == 2'b11) ? ~last_m : (r == 2'b10);
`endif
    last_m = w;
    d = w ? d1 : d0;
    l = int'(w ? l1 : l0);
    g = w ? 2'b10 : 2'b01;
    for (int c = 1; c <= l + 2; c++) begin
      @(negedge clk);
      if (c == 1)
        e = {g, 2'b00, 1'b1, 1'b1, d, 1'b0, 1'b0};
      else if (c <= l + 1)
        e = {g, 2'b00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      else
        e = {g, g, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
      chk($sformatf("%s_c%0d", tag, c), obs(), e);
      if (c == mut) begin
        data0 = 8'($urandom); data1 = 8'($urandom);
        len0 = 4'($urandom); len1 = 4'($urandom);
        req = 2'b00;
      end
      if (c == abort) begin
        rst = 1'b1;
        #1 chk({tag, "_rst"}, obs(), 16'h0);
        last_m = 1'b1;
        @(negedge clk);
        chk({tag, "_rsthold"}, obs(), 16'h0);
        rst = 1'b0;
        req = 2'b00;
        return;
      end
    end
    req = 2'b00;
    @(negedge clk);
    chk({tag, "_end"}, obs(), 16'h0);
  endtask

  initial begin
    rst = 1'b1; req = 2'b00;
    data0 = 8'h00; data1 = 8'h00; len0 = 4'h0; len1 = 4'h0;
    #1 chk("reset", obs(), 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    txn("basic", 2'b01, 8'h10, 8'h55, 4'd3, 4'd7, 0, 0);
    for (int i = 0; i < 4; i++)
      txn($sformatf("rr%0d", i), 2'b11, 8'hA0 + 8'(i), 8'hB0 + 8'(i),
          4'd1, 4'd1, 0, 0);
    txn("zero_len", 2'b10, 8'h01, 8'hFF, 4'd5, 4'd0, 0, 0);
    txn("abort", 2'b01, 8'h33, 8'h44, 4'd8, 4'd2, 0, 5);
    txn("post_rst", 2'b11, 8'h21, 8'h22, 4'd2, 4'd2, 0, 0);
    txn("ignore", 2'b01, 8'h5A, 8'hC3, 4'd6, 4'd4, 3, 0);
    txn("max_len", 2'b01, 8'h7E, 8'h00, 4'd15, 4'd1, 0, 0);
    txn("idle", 2'b00, 8'h00, 8'h00, 4'd0, 4'd0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      txn($sformatf("rnd%0d", i), 2'($urandom), 8'($urandom),
          8'($urandom), 4'($urandom), 4'($urandom),
          int'($urandom_range(0, 6)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_n, err_n);
    $finish;
  end

endmodule
